axi4lite_cmd_master: RTL

- Command-driven AXI4-Lite master that sits directly upstream of the register-file slave and drives its AW/W/B/AR/R channels.
- Accepts one single-beat read or write command over a valid/ready interface and runs the full AXI4-Lite transaction.
- Returns data and response over a valid/ready response interface.
- Strictly one transaction outstanding; a per-transaction timeout guards against a hung slave.

---
 rtl/axi4lite_cmd_master.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/axi4lite_cmd_master.sv
// Command-driven AXI4-Lite master: runs one single-beat read or write per command,
// returns data/response on a valid/ready channel, and aborts a hung slave after TIMEOUT bus-wait cycles.
module axi4lite_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW-1:0]   cmd_wdata,
    input  logic [DW/8-1:0] cmd_wstrb,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic [1:0]      rsp_resp,
    output logic            rsp_timeout,
    output logic            awvalid,
    input  logic            awready,
    output logic [AW-1:0]   awaddr,
    output logic            wvalid,
    input  logic            wready,
    output logic [DW-1:0]   wdata,
    output logic [DW/8-1:0] wstrb,
    input  logic            bvalid,
    output logic            bready,
    input  logic [1:0]      bresp,
    output logic            arvalid,
    input  logic            arready,
    output logic [AW-1:0]   araddr,
    input  logic            rvalid,
    output logic            rready,
    input  logic [DW-1:0]   rdata,
    input  logic [1:0]      rresp
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP} state_t;

    // Wide enough to hold TIMEOUT; saturates at all-ones so it never wraps.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_tmo_cnt;
    logic               r_aw_done, r_w_done;
    logic [AW-1:0]      r_addr;
    logic [DW-1:0]      r_wdata;
    logic [DW/8-1:0]    r_wstrb;
    logic               r_cmd_ready, r_rsp_valid, r_rsp_timeout;
    logic [DW-1:0]      r_rsp_rdata;
    logic [1:0]         r_rsp_resp;
    logic               r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;

    logic               w_accept, w_bus_state, w_tmo_hit, w_abort;
    logic               w_aw_done_nxt, w_w_done_nxt;
    logic               w_cmd_ready_nxt, w_rsp_valid_nxt, w_rsp_timeout_nxt;
    logic [DW-1:0]      w_rsp_rdata_nxt;
    logic [1:0]         w_rsp_resp_nxt;
    logic               w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt, w_arvalid_nxt, w_rready_nxt;

    assign w_accept      = (r_state == S_IDLE) & cmd_valid & r_cmd_ready;
    assign w_bus_state   = r_state inside {S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA};
    assign w_tmo_hit     = (TIMEOUT != 0) && w_bus_state && (r_tmo_cnt == CNT_W'(TIMEOUT));
    assign w_aw_done_nxt = r_aw_done | (r_awvalid & awready);
    assign w_w_done_nxt  = r_w_done  | (r_wvalid & wready);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_tmo_cnt     <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state)
                r_tmo_cnt <= '0;
            else if (w_bus_state && (r_tmo_cnt != '1))
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            r_aw_done <= (w_state_nxt == S_WR) & w_aw_done_nxt;
            r_w_done  <= (w_state_nxt == S_WR) & w_w_done_nxt;
            if (w_accept) begin
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
                r_wstrb <= cmd_wstrb;
            end
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_resp    <= w_rsp_resp_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_awvalid     <= w_awvalid_nxt;
            r_wvalid      <= w_wvalid_nxt;
            r_bready      <= w_bready_nxt;
            r_arvalid     <= w_arvalid_nxt;
            r_rready      <= w_rready_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = cmd_write ? S_WR : S_RD_ADDR;
            S_WR:      if (w_aw_done_nxt & w_w_done_nxt) w_state_nxt = S_WR_RESP;
            S_WR_RESP: if (bvalid & r_bready) w_state_nxt = S_RSP;
            S_RD_ADDR: if (r_arvalid & arready) w_state_nxt = S_RD_DATA;
            S_RD_DATA: if (rvalid & r_rready) w_state_nxt = S_RSP;
            S_RSP:     if (r_rsp_valid & rsp_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        // A handshake landing on the expiry cycle still completes normally.
        if (w_tmo_hit && (w_state_nxt == r_state)) begin
            w_abort     = 1'b1;
            w_state_nxt = S_RSP;
        end
    end

    always_comb begin
        w_cmd_ready_nxt   = (w_state_nxt == S_IDLE);
        w_awvalid_nxt     = (w_state_nxt == S_WR) & ~w_aw_done_nxt;
        w_wvalid_nxt      = (w_state_nxt == S_WR) & ~w_w_done_nxt;
        w_bready_nxt      = (w_state_nxt == S_WR_RESP);
        w_arvalid_nxt     = (w_state_nxt == S_RD_ADDR);
        w_rready_nxt      = (w_state_nxt == S_RD_DATA);
        w_rsp_valid_nxt   = (w_state_nxt == S_RSP);
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_resp_nxt    = r_rsp_resp;
        w_rsp_timeout_nxt = r_rsp_timeout;
        if (w_abort) begin
            w_rsp_rdata_nxt   = '0;
            w_rsp_resp_nxt    = 2'b10;
            w_rsp_timeout_nxt = 1'b1;
        end else if ((r_state == S_WR_RESP) && (w_state_nxt == S_RSP)) begin
            w_rsp_rdata_nxt   = '0;
            w_rsp_resp_nxt    = bresp;
            w_rsp_timeout_nxt = 1'b0;
        end else if ((r_state == S_RD_DATA) && (w_state_nxt == S_RSP)) begin
            w_rsp_rdata_nxt   = rdata;
            w_rsp_resp_nxt    = rresp;
            w_rsp_timeout_nxt = 1'b0;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_timeout = r_rsp_timeout;
    assign awvalid     = r_awvalid;
    assign awaddr      = r_addr;
    assign wvalid      = r_wvalid;
    assign wdata       = r_wdata;
    assign wstrb       = r_wstrb;
    assign bready      = r_bready;
    assign arvalid     = r_arvalid;
    assign araddr      = r_addr;
    assign rready      = r_rready;
endmodule
